// File: rtl/wordline_sequencer.sv
// Clocked wordline sequencer: accepts one access per handshake, then runs a timed
// precharge phase followed by a one-hot wordline phase and a one-cycle done pulse.
module wordline_sequencer #(
    parameter int ADDR_W        = 3,
    parameter int PRECHARGE_CYC = 1,
    parameter int ACTIVE_CYC    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ADDR_W-1:0]      i_address,
    input  logic                   i_write,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_precharge,
    output logic [(2**ADDR_W)-1:0] o_select,
    output logic                   o_write_en,
    output logic                   o_done
);

    localparam int ROWS = 2 ** ADDR_W;

    // Counter reload values are one less than the phase length: the phase ends on the cycle the counter reads 0.
    localparam logic [3:0] PRE_LOAD = (PRECHARGE_CYC > 0) ? 4'(PRECHARGE_CYC - 1) : 4'd0;
    localparam logic [3:0] ACT_LOAD = 4'(ACTIVE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ACT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;

    logic              ready_d, precharge_d, write_en_d, done_d;
    logic [ROWS-1:0]   select_d;
    logic              accept;

    assign accept = i_valid && o_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = i_address;
                    write_d = i_write;
                    if (PRECHARGE_CYC > 0) begin
                        state_d = PRE;
                        cnt_d   = PRE_LOAD;
                    end else begin
                        state_d = ACT;
                        cnt_d   = ACT_LOAD;
                    end
                end
            end
            PRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACT;
                    cnt_d   = ACT_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered with no input-to-output path.
        ready_d     = (state_d == IDLE);
        precharge_d = (state_d == PRE);
        select_d    = (state_d == ACT) ? (ROWS'(1) << addr_d) : '0;
        write_en_d  = (state_d == ACT) && write_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            o_ready     <= 1'b0;
            o_precharge <= 1'b0;
            o_select    <= '0;
            o_write_en  <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            o_ready     <= ready_d;
            o_precharge <= precharge_d;
            o_select    <= select_d;
            o_write_en  <= write_en_d;
            o_done      <= done_d;
        end
    end

endmodule

// File: tb/tb_wordline_sequencer.sv
// Self-checking bench for wordline_sequencer: directed and random accesses on two
// configurations, compared cycle by cycle against a phase-offset timing model.
module tb_wordline_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n;
    logic        i_valid, i_write;
    logic [3:0]  i_address;

    logic        a_ready, a_pre, a_we, a_done;
    logic [7:0]  a_sel;
    logic        b_ready, b_pre, b_we, b_done;
    logic [15:0] b_sel;

    wordline_sequencer #(.ADDR_W(3), .PRECHARGE_CYC(1), .ACTIVE_CYC(2)) dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_a_n),
        .i_address   (i_address[2:0]),
        .i_write     (i_write),
        .i_valid     (i_valid),
        .o_ready     (a_ready),
        .o_precharge (a_pre),
        .o_select    (a_sel),
        .o_write_en  (a_we),
        .o_done      (a_done)
    );

    wordline_sequencer #(.ADDR_W(4), .PRECHARGE_CYC(0), .ACTIVE_CYC(1)) dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_b_n),
        .i_address   (i_address),
        .i_write     (i_write),
        .i_valid     (i_valid),
        .o_ready     (b_ready),
        .o_precharge (b_pre),
        .o_select    (b_sel),
        .o_write_en  (b_we),
        .o_done      (b_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the whole access is described by the edge it was accepted on.
    bit cur;        // 0 = dut_a under test, 1 = dut_b
    int m_p, m_a;   // precharge / active lengths of the configuration under test
    int edge_n;     // edges since reset release
    int acc_e;      // edge of the most recent accept
    int m_addr;
    bit m_wr;
    bit m_ready;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s dut=%0d edge=%0d observed=%0h expected=%0h", tag, cur, edge_n, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph, input bit e_ready, input bit e_pre,
                                 input logic [15:0] e_sel, input bit e_we, input bit e_done);
        check({ph, "_ready"},     cur ? 16'(b_ready) : 16'(a_ready), 16'(e_ready));
        check({ph, "_precharge"}, cur ? 16'(b_pre)   : 16'(a_pre),   16'(e_pre));
        check({ph, "_select"},    cur ? b_sel        : {8'h00, a_sel}, e_sel);
        check({ph, "_write_en"},  cur ? 16'(b_we)    : 16'(a_we),    16'(e_we));
        check({ph, "_done"},      cur ? 16'(b_done)  : 16'(a_done),  16'(e_done));
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge and compare.
    task automatic tick(input bit v, input int addr, input bit wr);
        int k;
        bit act;
        i_valid   = v;
        i_address = 4'(addr);
        i_write   = wr;
        if (v && m_ready) begin
            acc_e  = edge_n + 1;
            m_addr = addr % (cur ? 16 : 8);
            m_wr   = wr;
        end
        @(posedge clk);
        #1;
        edge_n++;
        k       = edge_n + 1 - acc_e;   // cycle number relative to the accept edge
        act     = (k >= m_p + 1) && (k <= m_p + m_a);
        m_ready = !((k >= 1) && (k <= m_p + m_a));
        check_outputs("run", m_ready, (k >= 1) && (k <= m_p),
                      act ? (16'(1) << m_addr) : 16'h0000, act && m_wr, k == m_p + m_a + 1);
    endtask

    // Hold the selected DUT in reset with a live request, check it is quiet, then release.
    task automatic reset_dut(input bit which, input int p, input int a);
        cur = which;
        m_p = p;
        m_a = a;
        i_valid   = 1'b1;
        i_write   = 1'b1;
        i_address = 4'($urandom);
        if (which) rst_b_n = 1'b0;
        else       rst_a_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        if (which) rst_b_n = 1'b1;
        else       rst_a_n = 1'b1;
        edge_n  = 0;
        acc_e   = -1000;
        m_ready = 1'b0;
    endtask

    initial begin
        rst_a_n   = 1'b0;
        rst_b_n   = 1'b0;
        i_valid   = 1'b0;
        i_write   = 1'b0;
        i_address = '0;

        // Reset and idle: a request held across release must not start before ready rises.
        reset_dut(1'b0, 1, 2);
        tick(1'b1, 6, 1'b1);

        // Single write to row 5.
        tick(1'b0, 0, 1'b0);
        tick(1'b1, 5, 1'b1);
        repeat (4) tick(1'b0, $urandom_range(0, 7), 1'($urandom));

        // Sweep of reads, each accepted on the previous done cycle.
        for (int a = 0; a < 8; a++) begin
            tick(1'b1, a, 1'b0);
            repeat (3) tick(1'b0, $urandom_range(0, 7), 1'($urandom));
        end
        tick(1'b0, 0, 1'b0);

        // A request presented while busy is ignored.
        tick(1'b1, 2, 1'b0);
        tick(1'b1, 7, 1'b1);
        tick(1'b1, 7, 1'b1);
        tick(1'b1, 7, 1'b1);
        repeat (2) tick(1'b0, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 150; i++)
            tick(($urandom % 4) != 0, $urandom_range(0, 7), 1'($urandom));
        repeat (4) tick(1'b0, 0, 1'b0);

        // Reset in the first ACT cycle clears outputs at once and drops the access.
        tick(1'b1, 3, 1'b1);
        tick(1'b0, 0, 1'b0);
        #2;
        rst_a_n = 1'b0;
        #1;
        check_outputs("async_reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        reset_dut(1'b0, 1, 2);
        repeat (6) tick(1'b0, 0, 1'b0);

        // Skipped precharge, 16 rows.
        reset_dut(1'b1, 0, 1);
        tick(1'b0, 0, 1'b0);
        tick(1'b1, 15, 1'b1);
        repeat (3) tick(1'b0, 0, 1'b0);
        for (int i = 0; i < 100; i++)
            tick(($urandom % 3) != 0, $urandom_range(0, 15), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
